// File: rtl/clip_pkg.sv
// Shared types and defaults for the saturating clipper datapath.
// Consumers: sat_lane and sat_clip_pipe (optional stats enabled by CLIP_STATS_EN).
`timescale 1ns/1ps
package clip_pkg;

    typedef struct packed {
        logic lo;
        logic hi;
    } clip_flag_t;

    localparam int CLIP_NCH   = 3;
    localparam int CLIP_IN_W  = 32;
    localparam int CLIP_FRAC  = 16;
    localparam int CLIP_OUT_W = 8;

    function automatic logic [31:0] sat_max(input int unsigned outW);
        return (32'd1 << outW) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_lane.sv
// One colour lane of the clipper: S1 shifts out the fraction and flags the range,
// S2 registers the clamped unsigned result. Both stages advance together on advance_i.
`timescale 1ns/1ps
module sat_lane
    import clip_pkg::*;
#(
    parameter int IN_W  = CLIP_IN_W,
    parameter int FRAC  = CLIP_FRAC,
    parameter int OUT_W = CLIP_OUT_W
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               advance_i,
    input  logic [IN_W-1:0]    data_i,
    output logic [OUT_W-1:0]   data_o,
    output clip_flag_t         flag_o
);

    localparam logic signed [IN_W-1:0] MAX_S = IN_W'(sat_max(OUT_W));

    logic signed [IN_W-1:0] shifted;
    logic signed [IN_W-1:0] value_q;
    clip_flag_t             flagS1_d;
    clip_flag_t             flagS1_q;
    logic [OUT_W-1:0]       result_d;
    logic [OUT_W-1:0]       result_q;
    clip_flag_t             flagS2_q;
    logic                   unused_valueHigh;

    // Range test is done on the full-width value so extreme inputs never wrap.
    always_comb begin
        shifted     = $signed(data_i) >>> FRAC;
        flagS1_d.lo = shifted[IN_W-1];
        flagS1_d.hi = shifted > MAX_S;
    end

    always_comb begin
        result_d = value_q[OUT_W-1:0];
        if (flagS1_q.lo) begin
            result_d = '0;
        end else if (flagS1_q.hi) begin
            result_d = MAX_S[OUT_W-1:0];
        end
    end

    assign unused_valueHigh = ^value_q[IN_W-1:OUT_W];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            value_q  <= '0;
            flagS1_q <= '0;
            result_q <= '0;
            flagS2_q <= '0;
        end else if (advance_i) begin
            value_q  <= shifted;
            flagS1_q <= flagS1_d;
            result_q <= result_d;
            flagS2_q <= flagS1_q;
        end
    end

    assign data_o = result_q;
    assign flag_o = flagS2_q;

endmodule

// File: rtl/sat_clip_pipe.sv
// Multi-lane two-stage saturating clipper with valid/ready flow control.
// Define CLIP_STATS_EN to build the per-lane saturating low/high clamp counters.
`timescale 1ns/1ps
module sat_clip_pipe
    import clip_pkg::*;
#(
    parameter int NCH   = CLIP_NCH,
    parameter int IN_W  = CLIP_IN_W,
    parameter int FRAC  = CLIP_FRAC,
    parameter int OUT_W = CLIP_OUT_W,
    parameter int CNT_W = 16
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*IN_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*OUT_W-1:0]  out_data,
    output logic [NCH-1:0]        out_clip,
    input  logic                  stats_clr,
    output logic [NCH*CNT_W-1:0]  stats_lo,
    output logic [NCH*CNT_W-1:0]  stats_hi
);

    logic       run_q;
    logic       validS1_q;
    logic       validS2_q;
    logic       stall;
    logic       advance;
    logic       accept;
    logic       fire;
    clip_flag_t laneFlag [NCH];

    // run_q keeps in_ready low while in reset and until the first edge after release.
    always_comb begin
        stall    = validS2_q && !out_ready;
        advance  = !stall;
        in_ready = run_q && !stall;
        accept   = in_valid && in_ready;
        fire     = validS2_q && out_ready;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            run_q     <= 1'b0;
            validS1_q <= 1'b0;
            validS2_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (advance) begin
                validS1_q <= accept;
                validS2_q <= validS1_q;
            end
        end
    end

    assign out_valid = validS2_q;

    for (genvar k = 0; k < NCH; k++) begin : gLane
        sat_lane #(
            .IN_W  (IN_W),
            .FRAC  (FRAC),
            .OUT_W (OUT_W)
        ) uLane (
            .Clock     (Clock),
            .Resetn    (Resetn),
            .advance_i (advance),
            .data_i    (in_data[k*IN_W +: IN_W]),
            .data_o    (out_data[k*OUT_W +: OUT_W]),
            .flag_o    (laneFlag[k])
        );
        assign out_clip[k] = laneFlag[k].lo | laneFlag[k].hi;
    end

`ifdef CLIP_STATS_EN
    logic [CNT_W-1:0] loCnt_q [NCH];
    logic [CNT_W-1:0] loCnt_d [NCH];
    logic [CNT_W-1:0] hiCnt_q [NCH];
    logic [CNT_W-1:0] hiCnt_d [NCH];

    // Counters saturate at all-ones; a clear wins over a same-cycle increment.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            loCnt_d[k] = loCnt_q[k];
            hiCnt_d[k] = hiCnt_q[k];
            if (stats_clr) begin
                loCnt_d[k] = '0;
                hiCnt_d[k] = '0;
            end else if (fire) begin
                if (laneFlag[k].lo && (loCnt_q[k] != '1)) begin
                    loCnt_d[k] = loCnt_q[k] + 1'b1;
                end
                if (laneFlag[k].hi && (hiCnt_q[k] != '1)) begin
                    hiCnt_d[k] = hiCnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int k = 0; k < NCH; k++) begin
                loCnt_q[k] <= '0;
                hiCnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                loCnt_q[k] <= loCnt_d[k];
                hiCnt_q[k] <= hiCnt_d[k];
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : gStats
        assign stats_lo[k*CNT_W +: CNT_W] = loCnt_q[k];
        assign stats_hi[k*CNT_W +: CNT_W] = hiCnt_q[k];
    end
`else
    logic unused_statsClr;
    logic unused_fire;

    assign unused_statsClr = stats_clr;
    assign unused_fire     = fire;
    assign stats_lo        = '0;
    assign stats_hi        = '0;
`endif

endmodule

// File: tb/tb_sat_clip_pipe.sv
// Scoreboard bench for sat_clip_pipe: directed words, a stalled stream, a mid-flight reset,
// then randomized traffic checked against a floor-division/clamp reference model.
`timescale 1ns/1ps
module tb_sat_clip_pipe;

    localparam int NCH   = 3;
    localparam int IN_W  = 32;
    localparam int FRAC  = 16;
    localparam int OUT_W = 8;
`ifdef CLIP_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    typedef struct packed {
        logic [NCH*OUT_W-1:0] data;
        logic [NCH-1:0]       lo;
        logic [NCH-1:0]       hi;
    } exp_t;

    logic                  Clock;
    logic                  Resetn;
    logic                  in_valid;
    logic                  in_ready;
    logic [NCH*IN_W-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [NCH*OUT_W-1:0]  out_data;
    logic [NCH-1:0]        out_clip;
    logic                  stats_clr;
    logic [NCH*CNT_W-1:0]  stats_lo;
    logic [NCH*CNT_W-1:0]  stats_hi;

    int   tests = 0;
    int   fails = 0;
    exp_t scoreboard [$];
    int   edgesSinceRel;
    longint modelLo [NCH];
    longint modelHi [NCH];
    logic   prevStall;
    logic [NCH*OUT_W-1:0] prevData;
    logic [NCH-1:0]       prevClip;

    sat_clip_pipe #(
        .NCH   (NCH),
        .IN_W  (IN_W),
        .FRAC  (FRAC),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_clip  (out_clip),
        .stats_clr (stats_clr),
        .stats_lo  (stats_lo),
        .stats_hi  (stats_hi)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference: floor(x / 2^FRAC) by exact integer division, then clamp to [0, 2^OUT_W-1].
    function automatic exp_t refModel(input logic [NCH*IN_W-1:0] w);
        exp_t   e;
        longint x, r, v;
        longint scale;
        longint maxOut;
        scale  = longint'(1) << FRAC;
        maxOut = (longint'(1) << OUT_W) - 1;
        e      = '0;
        for (int k = 0; k < NCH; k++) begin
            x = longint'($signed(w[k*IN_W +: IN_W]));
            r = x % scale;
            if (r < 0) r = r + scale;
            v = (x - r) / scale;
            if (v < 0) begin
                e.lo[k] = 1'b1;
            end else if (v > maxOut) begin
                e.hi[k] = 1'b1;
                e.data[k*OUT_W +: OUT_W] = '1;
            end else begin
                e.data[k*OUT_W +: OUT_W] = OUT_W'(v);
            end
        end
        return e;
    endfunction

    function automatic logic [IN_W-1:0] randLane();
        logic [15:0] bnd [6];
        bnd = '{16'hFFFF, 16'h0000, 16'h0001, 16'h00FE, 16'h00FF, 16'h0100};
        case ($urandom_range(0, 3))
            0: return IN_W'($urandom());
            1: return {bnd[$urandom_range(0, 5)], 16'($urandom())};
            2: return ($urandom_range(0, 1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return {8'h00, 24'($urandom())};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus; the expected response is queued when the word is accepted.
    task automatic applyStimulus(input logic v, input logic [NCH*IN_W-1:0] d, input logic ordy,
                                 input logic clr, output logic accepted);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stats_clr = clr;
        @(negedge Clock);
        accepted = in_valid && in_ready;
        if (accepted) scoreboard.push_back(refModel(d));
        @(posedge Clock);
        #1;
    endtask

    task automatic sendWord(input logic [NCH*IN_W-1:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            applyStimulus(1'b1, d, 1'b1, 1'b0, acc);
        end
        in_valid = 1'b0;
        if (!acc) checkOutput("sendWord accept timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) edgesSinceRel <= 0;
        else         edgesSinceRel <= edgesSinceRel + 1;
    end

    // Monitor: pops the scoreboard on every output handshake and checks flow-control rules.
    always @(negedge Clock) begin
        exp_t e;
        logic [NCH*CNT_W-1:0] expLo, expHi;
        logic fire;
        if (!Resetn) begin
            checkOutput("reset out_valid", 64'(out_valid), 64'd0);
            checkOutput("reset in_ready", 64'(in_ready), 64'd0);
            checkOutput("reset out_data", 64'(out_data), 64'd0);
            checkOutput("reset out_clip", 64'(out_clip), 64'd0);
            checkOutput("reset stats", 64'(stats_lo | stats_hi), 64'd0);
            for (int k = 0; k < NCH; k++) begin
                modelLo[k] = 0;
                modelHi[k] = 0;
            end
            prevStall = 1'b0;
        end else begin
            checkOutput("in_ready", 64'(in_ready),
                        64'((edgesSinceRel >= 1) && !(out_valid && !out_ready)));
            if (prevStall) begin
                checkOutput("stall out_valid held", 64'(out_valid), 64'd1);
                checkOutput("stall out_data held", 64'(out_data), 64'(prevData));
                checkOutput("stall out_clip held", 64'(out_clip), 64'(prevClip));
            end
            expLo = '0;
            expHi = '0;
`ifdef CLIP_STATS_EN
            for (int k = 0; k < NCH; k++) begin
                expLo[k*CNT_W +: CNT_W] = CNT_W'(modelLo[k]);
                expHi[k*CNT_W +: CNT_W] = CNT_W'(modelHi[k]);
            end
`endif
            checkOutput("stats_lo", 64'(stats_lo), 64'(expLo));
            checkOutput("stats_hi", 64'(stats_hi), 64'(expHi));
            fire = out_valid && out_ready;
            e    = '0;
            if (fire) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected output word", 64'd1, 64'd0);
                end else begin
                    e = scoreboard.pop_front();
                    checkOutput("out_data", 64'(out_data), 64'(e.data));
                    checkOutput("out_clip", 64'(out_clip), 64'(e.lo | e.hi));
                end
            end
            for (int k = 0; k < NCH; k++) begin
                if (stats_clr) begin
                    modelLo[k] = 0;
                    modelHi[k] = 0;
                end else if (fire) begin
                    if (e.lo[k] && modelLo[k] < (longint'(1) << CNT_W) - 1) modelLo[k]++;
                    if (e.hi[k] && modelHi[k] < (longint'(1) << CNT_W) - 1) modelHi[k]++;
                end
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevClip  = out_clip;
        end
    end

    initial begin
        logic [NCH*IN_W-1:0] words [10];
        logic acc;
        int   idx;
        int   lat;

        Resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        stats_clr = 1'b0;
        repeat (3) @(posedge Clock);
        #1 Resetn = 1'b1;

        // Directed words: mixed clamps, truncation, and the input extremes.
        sendWord({32'h00FF_0000, 32'h0100_0000, 32'hFFFF_0000});
        sendWord({32'h0080_8000, 32'h0000_FFFF, 32'h00FF_FFFF});
        sendWord({32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000});
        idle(4);

        // Back-to-back stream with the sink stalling on cycles 4-6.
        for (int i = 0; i < 10; i++) words[i] = {randLane(), randLane(), randLane()};
        idx = 0;
        for (int c = 1; c <= 40 && idx < 10; c++) begin
            applyStimulus(1'b1, words[idx], !(c >= 4 && c <= 6), 1'b0, acc);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checkOutput("stream words accepted", 64'(idx), 64'd10);
        idle(4);

        // Reset with two words in flight drops them; the next word then takes two cycles.
        sendWord({32'h0001_0000, 32'h0002_0000, 32'h0003_0000});
        sendWord({32'h0004_0000, 32'h0005_0000, 32'h0006_0000});
        Resetn = 1'b0;
        #1;
        checkOutput("async reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("async reset in_ready", 64'(in_ready), 64'd0);
        scoreboard.delete();
        repeat (2) @(negedge Clock);
        @(posedge Clock);
        #1 Resetn = 1'b1;
        sendWord({32'h0042_0000, 32'hFF00_0000, 32'h0200_0000});
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (out_valid) break;
            lat++;
        end
        @(posedge Clock);
        #1;
        checkOutput("latency after reset", 64'(lat), 64'd2);
        idle(3);

`ifdef CLIP_STATS_EN
        // Five high clamps on lane 0 saturate the 2-bit counter; a clear on a clamp wins.
        for (int i = 0; i < 5; i++) sendWord({32'h0, 32'h0, 32'h0100_0000});
        idle(4);
        checkOutput("stats_hi lane0 saturated", 64'(stats_hi[CNT_W-1:0]), 64'd3);
        sendWord({32'h0, 32'h0, 32'h0100_0000});
        applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
        idle(2);
        checkOutput("stats_hi lane0 cleared", 64'(stats_hi[CNT_W-1:0]), 64'd0);
`endif

        // Randomized traffic with random sink back-pressure and occasional clears.
        for (int c = 0; c < 400; c++) begin
            applyStimulus($urandom_range(0, 9) < 7, {randLane(), randLane(), randLane()},
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc);
        end
        in_valid  = 1'b0;
        stats_clr = 1'b0;

        for (int c = 0; c < 50 && scoreboard.size() != 0; c++) idle(1);
        checkOutput("drain scoreboard empty", 64'(scoreboard.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
